uart_rx_cfg: RTL and testbench



---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_baud_tick.sv | 34 +++
 rtl/uart_rx_cfg.sv | 186 ++++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants, rx FSM encoding and width helper for the UART blocks.
package uart_pkg;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_ODD  = 1;
  localparam int unsigned PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_RESYNC
  } rx_state_e;

  // Ceiling log2, never below 1 so that counters always have at least one bit.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned p;
    r = 0;
    p = 1;
    while (p < v) begin
      p = p << 1;
      r = r + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator: one-clk tick every TICK_DIV clocks, restartable.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned BAUD_RATE  = 9600,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int unsigned TICK_DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int unsigned CW       = clog2(TICK_DIV);

  logic [CW-1:0] cnt;

  // Free-running divider; restart realigns the phase to the start edge.
  always_ff @(posedge clk) begin
    if (rst || restart) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == CW'(TICK_DIV - 1)) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + 1'b1;
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 5..9 data bits, optional parity, 1/2 stop bits,
// oversampled with 3-sample majority vote, error/break reporting and resync.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned BAUD_RATE  = 9600,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_serial,
  output logic                 rx_active,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_done,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det
);

  localparam int unsigned OSW = clog2(OVERSAMPLE);
  localparam int unsigned MID = OVERSAMPLE / 2;
  localparam int unsigned BIW = clog2(DATA_BITS);

  rx_state_e            state;
  logic [1:0]           sync_ff;
  logic                 sync_rx;
  logic                 tick;
  logic                 restart_c;
  logic [OSW-1:0]       samp_cnt;
  logic                 s_early;
  logic                 s_mid;
  logic [BIW-1:0]       bit_idx;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_pend;
  logic                 frm_pend;
  logic                 brk_pend;

  logic decide_c;
  logic bit_end_c;
  logic vote_c;
  logic exp_par_c;
  logic brk_now_c;
  logic frm_now_c;

  assign sync_rx = sync_ff[1];

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk) begin
    if (rst) sync_ff <= 2'b11;
    else     sync_ff <= {sync_ff[0], rx_serial};
  end

  // Bit phase is realigned on the falling edge that starts a frame.
  assign restart_c = (state == ST_IDLE) && !sync_rx;

  uart_baud_tick #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE),
    .OVERSAMPLE(OVERSAMPLE)
  ) u_tick (
    .clk    (clk),
    .rst    (rst),
    .restart(restart_c),
    .tick   (tick)
  );

  // Bit decision, expected parity and frame-end error terms.
  always_comb begin
    decide_c  = tick && (samp_cnt == OSW'(MID + 1));
    bit_end_c = tick && (samp_cnt == OSW'(OVERSAMPLE - 1));
    vote_c    = (s_early & s_mid) | (s_early & sync_rx) | (s_mid & sync_rx);
    exp_par_c = (PARITY == PAR_EVEN) ? ^shreg : ~^shreg;
    brk_now_c = (stop_idx == 1'b0) ? (brk_pend & ~vote_c) : brk_pend;
    frm_now_c = frm_pend | ~vote_c;
  end

  // Receive FSM with sample counter, shift register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      samp_cnt   <= '0;
      s_early    <= 1'b1;
      s_mid      <= 1'b1;
      bit_idx    <= '0;
      stop_idx   <= 1'b0;
      shreg      <= '0;
      par_pend   <= 1'b0;
      frm_pend   <= 1'b0;
      brk_pend   <= 1'b0;
      rx_active  <= 1'b0;
      rx_data    <= '0;
      rx_done    <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      break_det  <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      if (tick) samp_cnt <= (samp_cnt == OSW'(OVERSAMPLE - 1)) ? '0 : samp_cnt + 1'b1;
      if (tick && (samp_cnt == OSW'(MID - 1))) s_early <= sync_rx;
      if (tick && (samp_cnt == OSW'(MID)))     s_mid   <= sync_rx;

      case (state)
        ST_IDLE: begin
          if (!sync_rx) begin
            state     <= ST_START;
            rx_active <= 1'b1;
            samp_cnt  <= '0;
            bit_idx   <= '0;
            stop_idx  <= 1'b0;
            par_pend  <= 1'b0;
            frm_pend  <= 1'b0;
            brk_pend  <= 1'b1;
          end
        end

        ST_START: begin
          if (decide_c && vote_c) begin
            state     <= ST_IDLE;
            rx_active <= 1'b0;
          end else if (bit_end_c) begin
            state <= ST_DATA;
          end
        end

        ST_DATA: begin
          if (decide_c) begin
            shreg    <= {vote_c, shreg[DATA_BITS-1:1]};
            brk_pend <= brk_pend & ~vote_c;
          end
          if (bit_end_c) begin
            if (bit_idx == BIW'(DATA_BITS - 1))
              state <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
            else
              bit_idx <= bit_idx + 1'b1;
          end
        end

        ST_PARITY: begin
          if (decide_c) begin
            par_pend <= (vote_c != exp_par_c);
            brk_pend <= brk_pend & ~vote_c;
          end
          if (bit_end_c) state <= ST_STOP;
        end

        ST_STOP: begin
          if (decide_c) begin
            if (stop_idx == 1'(STOP_BITS - 1)) begin
              // Frame end at the final stop-bit decision; rest of the bit is skipped.
              rx_done    <= 1'b1;
              rx_data    <= shreg;
              parity_err <= par_pend;
              frame_err  <= frm_now_c;
              break_det  <= brk_now_c;
              rx_active  <= 1'b0;
              samp_cnt   <= '0;
              state      <= frm_now_c ? ST_RESYNC : ST_IDLE;
            end else begin
              frm_pend <= frm_now_c;
              brk_pend <= brk_now_c;
            end
          end
          if (bit_end_c) stop_idx <= 1'b1;
        end

        ST_RESYNC: begin
          // samp_cnt counts consecutive high ticks here.
          if (tick) begin
            if (!sync_rx)
              samp_cnt <= '0;
            else if (samp_cnt == OSW'(OVERSAMPLE - 1))
              state <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: three configurations (8N1, 7E1, 8N2) driven with
// directed and random frames, checked against a frame-level reference model.
module tb_uart_rx_cfg;
  import uart_pkg::*;

  localparam int unsigned CLK_FREQ = 50000000;
  localparam int unsigned BAUD     = 781250;   // TICK_DIV = 4, one bit = 64 clk
  localparam int unsigned OS       = 16;
  localparam int          BIT_T    = 1280;     // clock period is 20
  localparam int          FAST_T   = 1255;     // transmitter about 2% fast

  typedef struct {
    int         id;
    logic [8:0] data;
    logic       pe;
    logic       fe;
    logic       bk;
  } rec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] line;
  logic [2:0] act, done, pe, fe, bk;
  logic [7:0] d0;
  logic [6:0] d1;
  logic [7:0] d2;
  logic [8:0] dv [3];

  rec_t dq[$];
  rec_t eq[$];
  int   errors = 0;
  int   checks = 0;
  int   act_bad = 0;
  logic [2:0] pend = 3'b000;
  logic saw_resync = 1'b0;

  always #10 clk = ~clk;

  uart_rx_cfg #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .DATA_BITS(8), .PARITY(0),
                .STOP_BITS(1), .OVERSAMPLE(OS)) dut0 (
    .clk(clk), .rst(rst), .rx_serial(line[0]), .rx_active(act[0]), .rx_data(d0),
    .rx_done(done[0]), .parity_err(pe[0]), .frame_err(fe[0]), .break_det(bk[0]));

  uart_rx_cfg #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .DATA_BITS(7), .PARITY(2),
                .STOP_BITS(1), .OVERSAMPLE(OS)) dut1 (
    .clk(clk), .rst(rst), .rx_serial(line[1]), .rx_active(act[1]), .rx_data(d1),
    .rx_done(done[1]), .parity_err(pe[1]), .frame_err(fe[1]), .break_det(bk[1]));

  uart_rx_cfg #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .DATA_BITS(8), .PARITY(0),
                .STOP_BITS(2), .OVERSAMPLE(OS)) dut2 (
    .clk(clk), .rst(rst), .rx_serial(line[2]), .rx_active(act[2]), .rx_data(d2),
    .rx_done(done[2]), .parity_err(pe[2]), .frame_err(fe[2]), .break_det(bk[2]));

  assign dv[0] = {1'b0, d0};
  assign dv[1] = {2'b00, d1};
  assign dv[2] = {1'b0, d2};

  // Capture every done strobe and watch rx_active the cycle after it.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (pend[k] && act[k]) act_bad++;
      if (done[k]) begin
        rec_t r;
        r.id   = k;
        r.data = dv[k];
        r.pe   = pe[k];
        r.fe   = fe[k];
        r.bk   = bk[k];
        dq.push_back(r);
      end
    end
    pend = done;
    if (dut2.state == ST_RESYNC) saw_resync = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Frame-level reference: what a receiver must report for the bits put on the line.
  function automatic rec_t model(input int id, input logic [8:0] data, input int nbits,
                                 input int unsigned pmode, input logic par_bit,
                                 input logic [1:0] stops, input int nstop);
    rec_t r;
    int   ones;
    logic exp_par;
    r.id    = id;
    r.data  = data & 9'((1 << nbits) - 1);
    ones    = $countones(r.data);
    exp_par = (pmode == PAR_EVEN) ? ones[0] : ~ones[0];
    r.pe    = (pmode != PAR_NONE) && (par_bit != exp_par);
    r.fe    = !stops[0] || (nstop == 2 && !stops[1]);
    r.bk    = (r.data == 9'd0) && (pmode == PAR_NONE || !par_bit) && !stops[0];
    return r;
  endfunction

  task automatic send_bit(input int k, input logic v, input int t);
    line[k] = v;
    #(t);
  endtask

  task automatic send_frame(input int k, input logic [8:0] data, input int nbits,
                            input bit has_par, input logic par_bit,
                            input logic [1:0] stops, input int nstop, input int t);
    send_bit(k, 1'b0, t);
    for (int i = 0; i < nbits; i++) send_bit(k, data[i], t);
    if (has_par) send_bit(k, par_bit, t);
    for (int i = 0; i < nstop; i++) send_bit(k, stops[i], t);
    line[k] = 1'b1;
  endtask

  task automatic idle(input int nbits);
    #(nbits * BIT_T);
  endtask

  // Compare captured frames against expectations, then clear both lists.
  task automatic check_all(input string tag);
    chk($sformatf("%s_count", tag), dq.size(), eq.size());
    for (int i = 0; i < eq.size() && i < dq.size(); i++) begin
      chk($sformatf("%s[%0d]_id", tag, i), dq[i].id, eq[i].id);
      chk($sformatf("%s[%0d]_data", tag, i), 32'(dq[i].data), 32'(eq[i].data));
      chk($sformatf("%s[%0d]_perr", tag, i), 32'(dq[i].pe), 32'(eq[i].pe));
      chk($sformatf("%s[%0d]_ferr", tag, i), 32'(dq[i].fe), 32'(eq[i].fe));
      chk($sformatf("%s[%0d]_brk", tag, i), 32'(dq[i].bk), 32'(eq[i].bk));
    end
    dq.delete();
    eq.delete();
  endtask

  initial begin
    logic [8:0] d;
    logic       p;
    logic [1:0] s;
    logic [8:0] last0;
    rec_t       r;

    rst  = 1'b1;
    line = 3'b111;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("rst_active", 32'(act), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_perr", 32'(pe), 0);
    chk("rst_ferr", 32'(fe), 0);
    chk("rst_brk", 32'(bk), 0);
    chk("rst_data0", 32'(d0), 0);
    chk("rst_data1", 32'(d1), 0);
    chk("rst_data2", 32'(d2), 0);
    rst = 1'b0;
    idle(2);

    // 8N1 0xA5, with rx_active observed mid-frame.
    eq.push_back(model(0, 9'h0A5, 8, PAR_NONE, 1'b0, 2'b11, 1));
    fork
      send_frame(0, 9'h0A5, 8, 1'b0, 1'b0, 2'b11, 1, BIT_T);
      begin
        #(BIT_T * 4);
        chk("active_mid_frame", 32'(act[0]), 1);
      end
    join
    idle(2);
    check_all("8n1_a5");

    // 8N1 random words.
    for (int n = 0; n < 4; n++) begin
      d = 9'($urandom_range(0, 255));
      r = model(0, d, 8, PAR_NONE, 1'b0, 2'b11, 1);
      eq.push_back(r);
      last0 = r.data;
      send_frame(0, d, 8, 1'b0, 1'b0, 2'b11, 1, BIT_T);
      idle(1);
    end
    idle(1);
    check_all("8n1_rand");

    // 7E1: 0x35 with correct then wrong parity, then random words and parity bits.
    eq.push_back(model(1, 9'h035, 7, PAR_EVEN, 1'b0, 2'b11, 1));
    send_frame(1, 9'h035, 7, 1'b1, 1'b0, 2'b11, 1, BIT_T);
    idle(1);
    eq.push_back(model(1, 9'h035, 7, PAR_EVEN, 1'b1, 2'b11, 1));
    send_frame(1, 9'h035, 7, 1'b1, 1'b1, 2'b11, 1, BIT_T);
    idle(1);
    for (int n = 0; n < 4; n++) begin
      d = 9'($urandom_range(0, 127));
      p = 1'($urandom_range(0, 1));
      eq.push_back(model(1, d, 7, PAR_EVEN, p, 2'b11, 1));
      send_frame(1, d, 7, 1'b1, p, 2'b11, 1, BIT_T);
      idle(1);
    end
    idle(1);
    check_all("7e1");

    // Glitch shorter than half a bit is rejected and leaves rx_data alone.
    line[0] = 1'b0;
    #(BIT_T / 5);
    line[0] = 1'b1;
    idle(2);
    check_all("glitch");
    chk("glitch_active", 32'(act[0]), 0);
    chk("glitch_hold", 32'(d0), 32'(last0));

    // 8N2 with the second stop bit low, recovery, then clean frame and random stops.
    saw_resync = 1'b0;
    eq.push_back(model(2, 9'h03C, 8, PAR_NONE, 1'b0, 2'b01, 2));
    send_frame(2, 9'h03C, 8, 1'b0, 1'b0, 2'b01, 2, BIT_T);
    idle(10);
    chk("8n2_resync_seen", 32'(saw_resync), 1);
    eq.push_back(model(2, 9'h081, 8, PAR_NONE, 1'b0, 2'b11, 2));
    send_frame(2, 9'h081, 8, 1'b0, 1'b0, 2'b11, 2, BIT_T);
    idle(2);
    for (int n = 0; n < 4; n++) begin
      d = 9'($urandom_range(0, 255));
      s = 2'($urandom_range(0, 3));
      eq.push_back(model(2, d, 8, PAR_NONE, 1'b0, s, 2));
      send_frame(2, d, 8, 1'b0, 1'b0, s, 2, BIT_T);
      idle(2);
    end
    check_all("8n2");

    // Break: 12 bit times low produces one frame, then a normal frame follows.
    eq.push_back(model(0, 9'h000, 8, PAR_NONE, 1'b0, 2'b00, 1));
    line[0] = 1'b0;
    #(12 * BIT_T);
    line[0] = 1'b1;
    idle(2);
    eq.push_back(model(0, 9'h05A, 8, PAR_NONE, 1'b0, 2'b11, 1));
    send_frame(0, 9'h05A, 8, 1'b0, 1'b0, 2'b11, 1, BIT_T);
    idle(2);
    check_all("break");

    // Back-to-back frames from a 2% fast transmitter.
    eq.push_back(model(0, 9'h000, 8, PAR_NONE, 1'b0, 2'b11, 1));
    eq.push_back(model(0, 9'h0FF, 8, PAR_NONE, 1'b0, 2'b11, 1));
    eq.push_back(model(0, 9'h055, 8, PAR_NONE, 1'b0, 2'b11, 1));
    send_frame(0, 9'h000, 8, 1'b0, 1'b0, 2'b11, 1, FAST_T);
    send_frame(0, 9'h0FF, 8, 1'b0, 1'b0, 2'b11, 1, FAST_T);
    send_frame(0, 9'h055, 8, 1'b0, 1'b0, 2'b11, 1, FAST_T);
    idle(2);
    check_all("b2b_fast");

    // Reset in the middle of a data bit abandons the frame.
    fork
      send_frame(0, 9'h0FF, 8, 1'b0, 1'b0, 2'b11, 1, BIT_T);
      begin
        #(BIT_T * 4 + BIT_T / 2);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid_active", 32'(act[0]), 0);
        chk("rstmid_done", 32'(done[0]), 0);
        chk("rstmid_data", 32'(d0), 0);
        chk("rstmid_flags", 32'({pe[0], fe[0], bk[0]}), 0);
        rst = 1'b0;
      end
    join
    idle(3);
    check_all("rst_mid");

    chk("active_after_done", act_bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
